// File: rtl/ew_arb_pkg.sv
// Shared types for the east/west single-lane arbiter.
package ew_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_E = 2'b01,
        GNT_W = 2'b10,
        CLEAR = 2'b11
    } arb_state_t;

    localparam logic DIR_E = 1'b0;
    localparam logic DIR_W = 1'b1;

endpackage

// File: rtl/arb_cycle_timer.sv
// Phase cycle counter: synchronous clear/load-to-1, saturating increment.
module arb_cycle_timer #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic          inc,
    input  logic [CW-1:0] sat,
    output logic [CW-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(1);
        end else if (inc && (cnt < sat)) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ew_lane_arbiter.sv
// Shares one single-lane resource between east and west requesters with
// min/max green times, a clearance gap between grants and tie alternation.
module ew_lane_arbiter
    import ew_arb_pkg::*;
#(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 16,
    parameter int CLEAR_CYC = 3,
    parameter int CW        = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_e,
    input  logic          req_w,
    output logic          grant_e,
    output logic          grant_w,
    output logic          clear_o,
    output logic          idle_o,
    output logic          last_dir,
    output logic [CW-1:0] gnt_cnt
);

    localparam logic [CW-1:0] MIN_C = CW'(GREEN_MIN);
    localparam logic [CW-1:0] MAX_C = CW'(GREEN_MAX);
    localparam logic [CW-1:0] CLR_C = CW'(CLEAR_CYC);

    arb_state_t    state;
    arb_state_t    arb_nxt;
    logic          own_req;
    logic          opp_req;
    logic          go_clear;
    logic          clear_done;
    logic          t_clr;
    logic          t_load;
    logic          t_inc;
    logic [CW-1:0] t_sat;

    // Ties go to the side that did not hold the lane last.
    function automatic arb_state_t arb(input logic re, input logic rw, input logic last);
        if (re && rw)  return (last == DIR_E) ? GNT_W : GNT_E;
        else if (re)   return GNT_E;
        else if (rw)   return GNT_W;
        else           return IDLE;
    endfunction

    always_comb begin
        arb_nxt    = arb(req_e, req_w, last_dir);
        own_req    = (state == GNT_W) ? req_w : req_e;
        opp_req    = (state == GNT_W) ? req_e : req_w;
        go_clear   = ((state == GNT_E) || (state == GNT_W)) && (gnt_cnt >= MIN_C) &&
                     (!own_req || (opp_req && (gnt_cnt == MAX_C)));
        clear_done = (state == CLEAR) && (gnt_cnt == CLR_C);
        t_load     = (((state == IDLE) || clear_done) && (arb_nxt != IDLE)) || go_clear;
        t_clr      = clear_done && (arb_nxt == IDLE);
        t_inc      = (state != IDLE);
        t_sat      = (state == CLEAR) ? CLR_C : MAX_C;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last_dir <= DIR_W;
        end else begin
            case (state)
                IDLE: state <= arb_nxt;
                GNT_E, GNT_W: begin
                    if (go_clear) begin
                        state    <= CLEAR;
                        last_dir <= (state == GNT_W) ? DIR_W : DIR_E;
                    end
                end
                CLEAR: begin
                    if (clear_done) state <= arb_nxt;
                end
                default: state <= IDLE;
            endcase
        end
    end

    arb_cycle_timer #(.CW(CW)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (t_clr),
        .load (t_load),
        .inc  (t_inc),
        .sat  (t_sat),
        .cnt  (gnt_cnt)
    );

    assign grant_e = (state == GNT_E);
    assign grant_w = (state == GNT_W);
    assign clear_o = (state == CLEAR);
    assign idle_o  = (state == IDLE);

endmodule

// File: tb/tb_ew_lane_arbiter.sv
// Self-checking bench: directed scenarios plus random requests against a
// phase/elapsed-time reference model, on a default and a short-timing instance.
module tb_ew_lane_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic re0 = 1'b0, rw0 = 1'b0, re1 = 1'b0, rw1 = 1'b0;
    logic ge0, gw0, cl0, id0, ld0, ge1, gw1, cl1, id1, ld1;
    logic [4:0] cnt0, cnt1;
    logic rand1 = 1'b0;

    int ntests = 0;
    int nfail  = 0;

    // model: phase 0=idle 1=grant 2=clear, unbounded elapsed-cycle count
    int m_phase[2], m_dir[2], m_last[2], m_el[2];
    int P_MIN[2] = '{4, 1};
    int P_MAX[2] = '{16, 16};
    int P_CLR[2] = '{3, 1};

    always #5 clk = ~clk;

    ew_lane_arbiter u0 (
        .clk(clk), .rst(rst), .req_e(re0), .req_w(rw0),
        .grant_e(ge0), .grant_w(gw0), .clear_o(cl0), .idle_o(id0),
        .last_dir(ld0), .gnt_cnt(cnt0)
    );

    ew_lane_arbiter #(.GREEN_MIN(1), .GREEN_MAX(16), .CLEAR_CYC(1), .CW(5)) u1 (
        .clk(clk), .rst(rst), .req_e(re1), .req_w(rw1),
        .grant_e(ge1), .grant_w(gw1), .clear_o(cl1), .idle_o(id1),
        .last_dir(ld1), .gnt_cnt(cnt1)
    );

    function automatic int arb(int re, int rw, int last);
        if (re != 0 && rw != 0) return 1 - last;
        if (re != 0) return 0;
        if (rw != 0) return 1;
        return -1;
    endfunction

    task automatic model_reset(int k);
        m_phase[k] = 0; m_dir[k] = 0; m_last[k] = 1; m_el[k] = 0;
    endtask

    task automatic model_step(int k, int re, int rw);
        int d, own, opp, c;
        case (m_phase[k])
            0: begin
                d = arb(re, rw, m_last[k]);
                if (d >= 0) begin m_phase[k] = 1; m_dir[k] = d; m_el[k] = 1; end
            end
            1: begin
                own = (m_dir[k] == 1) ? rw : re;
                opp = (m_dir[k] == 1) ? re : rw;
                c   = (m_el[k] > P_MAX[k]) ? P_MAX[k] : m_el[k];
                if (c >= P_MIN[k] && (own == 0 || (opp != 0 && c == P_MAX[k]))) begin
                    m_phase[k] = 2; m_last[k] = m_dir[k]; m_el[k] = 1;
                end else begin
                    m_el[k]++;
                end
            end
            default: begin
                if (m_el[k] == P_CLR[k]) begin
                    d = arb(re, rw, m_last[k]);
                    if (d >= 0) begin m_phase[k] = 1; m_dir[k] = d; m_el[k] = 1; end
                    else begin m_phase[k] = 0; m_el[k] = 0; end
                end else begin
                    m_el[k]++;
                end
            end
        endcase
    endtask

    function automatic logic [9:0] exp_vec(int k);
        int v;
        v = (m_phase[k] == 1 && m_el[k] > P_MAX[k]) ? P_MAX[k] : m_el[k];
        return {m_phase[k] == 1 && m_dir[k] == 0, m_phase[k] == 1 && m_dir[k] == 1,
                m_phase[k] == 2, m_phase[k] == 0, 1'(m_last[k]), 5'(v)};
    endfunction

    task automatic check(string tag, logic [9:0] obs, logic [9:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0, int'(re0), int'(rw0));
        model_step(1, int'(re1), int'(rw1));
        #1;
        check("model0", {ge0, gw0, cl0, id0, ld0, cnt0}, exp_vec(0));
        check("model1", {ge1, gw1, cl1, id1, ld1, cnt1}, exp_vec(1));
        check("mutex", {8'd0, ge0 & gw0, ge1 & gw1}, 10'd0);
        if (rand1) begin
            re1 = 1'($urandom_range(0, 1));
            rw1 = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset(0); model_reset(1);
        #1;
        check("rst0", {ge0, gw0, cl0, id0, ld0, cnt0}, 10'b0001_1_00000);
        check("rst1", {ge1, gw1, cl1, id1, ld1, cnt1}, 10'b0001_1_00000);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n_ge, n_cl, n_gw;
        logic [4:0] seen;
        logic       hit;

        #1 rst = 1'b1;
        model_reset(0); model_reset(1);
        #1;
        check("reset0", {ge0, gw0, cl0, id0, ld0, cnt0}, 10'b0001_1_00000);
        check("reset1", {ge1, gw1, cl1, id1, ld1, cnt1}, 10'b0001_1_00000);
        @(negedge clk);
        rst = 1'b0;

        // single-cycle east pulse on u0, single-cycle west pulse on u1
        re0 = 1'b1; rw1 = 1'b1;
        n_ge = 0; n_cl = 0; n_gw = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0) begin re0 = 1'b0; rw1 = 1'b0; end
            n_ge += int'(ge0); n_cl += int'(cl0); n_gw += int'(gw1);
        end
        check("pulse_e_len", 10'(n_ge), 10'd4);
        check("pulse_e_clear", 10'(n_cl), 10'd3);
        check("pulse_e_end", {8'd0, id0, ld0}, 10'b10);
        check("pulse_w1_len", 10'(n_gw), 10'd1);
        check("pulse_w1_end", {8'd0, id1, ld1}, 10'b11);

        // both requesting from reset release: strict alternation
        do_reset();
        re0 = 1'b1; rw0 = 1'b1;
        rand1 = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 16) check("alt_e_end", {4'd0, ge0, cnt0}, {4'd0, 1'b1, 5'd16});
            if (i == 17) check("alt_clr1", {9'd0, cl0}, 10'd1);
            if (i == 20) check("alt_w_start", {4'd0, gw0, cnt0}, {4'd0, 1'b1, 5'd1});
            if (i == 35) check("alt_w_end", {4'd0, gw0, cnt0}, {4'd0, 1'b1, 5'd16});
            if (i == 39) check("alt_e_again", {9'd0, ge0}, 10'd1);
        end

        // east alone holds indefinitely, west arrival forces a handover
        re0 = 1'b0; rw0 = 1'b0;
        repeat (25) step();
        re0 = 1'b1;
        repeat (45) step();
        check("hold_sat", {4'd0, ge0, cnt0}, {4'd0, 1'b1, 5'd16});
        rw0 = 1'b1;
        step();
        check("hold_to_clear", {9'd0, cl0}, 10'd1);
        repeat (3) step();
        check("hold_then_w", {9'd0, gw0}, 10'd1);

        // west joins at cnt 2, east releases at cnt 6
        re0 = 1'b0; rw0 = 1'b0;
        repeat (25) step();
        re0 = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            check("mid_grant_e", {4'd0, ge0, cnt0}, {4'd0, 1'b1, 5'(i)});
            if (i == 2) rw0 = 1'b1;
            if (i == 6) re0 = 1'b0;
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            check("mid_clear", {4'd0, cl0, cnt0}, {4'd0, 1'b1, 5'(i)});
        end
        step();
        check("mid_then_w", {9'd0, gw0}, 10'd1);

        // async reset in the middle of a west grant
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            seen = cnt0;
            if (gw0 && seen == 5'd5) hit = 1'b1;
            else step();
        end
        check("reach_w5", {9'd0, hit}, 10'd1);
        #2 rst = 1'b1;
        model_reset(0); model_reset(1);
        #1;
        check("async_rst0", {ge0, gw0, cl0, id0, ld0, cnt0}, 10'b0001_1_00000);
        check("async_rst1", {ge1, gw1, cl1, id1, ld1, cnt1}, 10'b0001_1_00000);
        @(negedge clk);
        re0 = 1'b1; rw0 = 1'b1;
        rst = 1'b0;
        step();
        check("post_rst_east", {8'd0, ge0, gw0}, 10'b10);

        // random requests with varying bias
        for (int blk = 0; blk < 8; blk++) begin
            int bias;
            bias = 1 + (blk % 4);
            for (int i = 0; i < 100; i++) begin
                re0 = ($urandom_range(0, 4) < bias) ? 1'b1 : 1'b0;
                rw0 = ($urandom_range(0, 4) < bias) ? 1'b1 : 1'b0;
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
